// File: rtl/tdc_multichannel.sv
// Multi-channel counter TDC: per-channel start->stop cycle count, saturating with sticky overflow.
// Edge pulses trail inputs by SYNC_STAGES cycles; results are held until acknowledged through the sel mux.
module tdc_multichannel #(
  parameter  int CHANNELS    = 4,
  parameter  int WIDTH       = 8,
  parameter  int SYNC_STAGES = 2,
  localparam int SEL_W       = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [CHANNELS-1:0] arm,
  input  logic [CHANNELS-1:0] start_in,
  input  logic [CHANNELS-1:0] stop_in,
  input  logic                mode,
  input  logic [SEL_W-1:0]    sel,
  input  logic                rd_ack,
  output logic [WIDTH-1:0]    count_out,
  output logic                ovf_out,
  output logic [CHANNELS-1:0] done,
  output logic [CHANNELS-1:0] busy
);

  typedef enum logic [1:0] {S_IDLE, S_ARMED, S_RUN, S_DONE} state_t;

  localparam logic [WIDTH-1:0] CNT_MAX = '1;
  localparam int               SEL_N   = 2 ** SEL_W;

  logic [WIDTH-1:0] w_res     [CHANNELS];
  logic             w_res_ovf [CHANNELS];

  for (genvar g = 0; g < CHANNELS; g++) begin : g_ch
    logic [SYNC_STAGES-1:0] r_start_sync;
    logic [SYNC_STAGES-1:0] r_stop_sync;
    logic                   r_start_prev;
    logic                   r_stop_prev;
    state_t                 r_state;
    logic [WIDTH-1:0]       r_cnt;
    logic [WIDTH-1:0]       r_result;
    logic                   r_ovf;
    logic                   r_res_ovf;
    logic                   r_done;
    logic                   r_busy;
    logic                   w_start_edge;
    logic                   w_stop_edge;
    logic                   w_ack;

    assign w_start_edge = r_start_sync[SYNC_STAGES-1] & ~r_start_prev;
    assign w_stop_edge  = r_stop_sync[SYNC_STAGES-1]  & ~r_stop_prev;
    // Out-of-range sel never matches any channel, so its rd_ack is inert.
    assign w_ack        = rd_ack && (sel == SEL_W'(g));

    always_ff @(posedge clk) begin
      if (rst) begin
        r_start_sync <= '0;
        r_stop_sync  <= '0;
        r_start_prev <= 1'b0;
        r_stop_prev  <= 1'b0;
        r_state      <= S_IDLE;
        r_cnt        <= '0;
        r_result     <= '0;
        r_ovf        <= 1'b0;
        r_res_ovf    <= 1'b0;
        r_done       <= 1'b0;
        r_busy       <= 1'b0;
      end else begin
        r_start_sync <= {r_start_sync[SYNC_STAGES-2:0], start_in[g]};
        r_stop_sync  <= {r_stop_sync[SYNC_STAGES-2:0], stop_in[g]};
        r_start_prev <= r_start_sync[SYNC_STAGES-1];
        r_stop_prev  <= r_stop_sync[SYNC_STAGES-1];
        case (r_state)
          S_IDLE: begin
            if (arm[g]) begin
              r_state <= S_ARMED;
              r_busy  <= 1'b1;
            end
          end
          S_ARMED: begin
            if (w_start_edge) begin
              r_state <= S_RUN;
              r_cnt   <= '0;
              r_ovf   <= 1'b0;
            end
          end
          S_RUN: begin
            if (w_stop_edge) begin
              r_state   <= S_DONE;
              r_busy    <= 1'b0;
              r_done    <= 1'b1;
              r_result  <= (r_cnt == CNT_MAX) ? CNT_MAX : r_cnt + 1'b1;
              r_res_ovf <= r_ovf | (r_cnt == CNT_MAX);
            end else if (r_cnt == CNT_MAX) begin
              r_ovf <= 1'b1;
            end else begin
              r_cnt <= r_cnt + 1'b1;
            end
          end
          S_DONE: begin
            if (w_ack) begin
              r_done <= 1'b0;
              if (mode) begin
                r_state <= S_ARMED;
                r_busy  <= 1'b1;
              end else begin
                r_state <= S_IDLE;
              end
            end
          end
          default: begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
          end
        endcase
      end
    end

    assign done[g]      = r_done;
    assign busy[g]      = r_busy;
    assign w_res[g]     = r_result;
    assign w_res_ovf[g] = r_res_ovf;
  end

  // Pad the read mux to the full select range so unused codes read as zero.
  logic [WIDTH-1:0] w_res_pad [SEL_N];
  logic             w_ovf_pad [SEL_N];

  for (genvar p = 0; p < SEL_N; p++) begin : g_pad
    if (p < CHANNELS) begin : g_used
      assign w_res_pad[p] = w_res[p];
      assign w_ovf_pad[p] = w_res_ovf[p];
    end else begin : g_unused
      assign w_res_pad[p] = '0;
      assign w_ovf_pad[p] = 1'b0;
    end
  end

  assign count_out = w_res_pad[sel];
  assign ovf_out   = w_ovf_pad[sel];

endmodule

// File: tb/tb_tdc_multichannel.sv
// Bench for tdc_multichannel: stimulus pushes expected results; a monitor checks them on each acknowledged read.
module tb_tdc_multichannel;
  localparam int CH = 6;
  localparam int W  = 8;
  localparam int SS = 2;
  localparam int SW = 3;

  logic          clk = 1'b0;
  logic          rst;
  logic [CH-1:0] arm, start_in, stop_in;
  logic          mode;
  logic [SW-1:0] sel;
  logic          rd_ack;
  logic [W-1:0]  count_out;
  logic          ovf_out;
  logic [CH-1:0] done, busy;

  always #5 clk = ~clk;

  tdc_multichannel #(.CHANNELS(CH), .WIDTH(W), .SYNC_STAGES(SS)) dut (
    .clk(clk), .rst(rst), .arm(arm), .start_in(start_in), .stop_in(stop_in),
    .mode(mode), .sel(sel), .rd_ack(rd_ack), .count_out(count_out),
    .ovf_out(ovf_out), .done(done), .busy(busy)
  );

  typedef struct {int ch; int cnt; bit ovf;} exp_t;
  exp_t sb_q[$];
  int   n_vec = 0;
  int   n_bad = 0;

  task automatic check(string name, logic [31:0] act, logic [31:0] req);
    n_vec++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", name, act, req);
    end
  endtask

  // Monitor: every acknowledged read of a done channel must match the oldest expectation.
  always @(negedge clk) begin
    exp_t e;
    if (!rst && rd_ack && int'(sel) < CH && done[sel] === 1'b1) begin
      if (sb_q.size() == 0) begin
        n_vec++;
        n_bad++;
        $display("FAIL unexpected_result: ch %0d count %0d, none expected", sel, count_out);
      end else begin
        e = sb_q.pop_front();
        check("result_ch", 32'(sel), e.ch);
        check("result_count", 32'(count_out), e.cnt);
        check("result_ovf", 32'(ovf_out), 32'(e.ovf));
      end
    end
  end

  task automatic tick(int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_arm(int ch);
    arm[ch] = 1'b1;
    tick();
    arm[ch] = 1'b0;
  endtask

  // Stop rises exactly n cycles after start, so the measured count is n.
  task automatic measure(int ch, int n, int exp_cnt, bit exp_ovf);
    start_in[ch] = 1'b1;
    tick();
    start_in[ch] = 1'b0;
    tick(n - 1);
    stop_in[ch] = 1'b1;
    sb_q.push_back(exp_t'{ch, exp_cnt, exp_ovf});
    tick();
    stop_in[ch] = 1'b0;
  endtask

  task automatic wait_done(int ch);
    int k = 0;
    while (done[ch] !== 1'b1 && k < 60) begin
      tick();
      k++;
    end
    check("done_wait", 32'(done[ch]), 1);
  endtask

  task automatic read(int ch, bit m);
    sel    = SW'(ch);
    mode   = m;
    rd_ack = 1'b1;
    tick();
    rd_ack = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; arm = '0; start_in = '0; stop_in = '0;
    mode = 1'b0; sel = '0; rd_ack = 1'b0;
    tick(3);
    rst = 1'b0;
    tick();
    check("reset_done", 32'(done), 0);
    check("reset_busy", 32'(busy), 0);
    check("reset_count", 32'(count_out), 0);
    check("reset_ovf", 32'(ovf_out), 0);

    // Basic single-shot
    do_arm(0);
    check("armed_busy", 32'(busy[0]), 1);
    measure(0, 10, 10, 0);
    wait_done(0);
    read(0, 0);
    check("ack_done_clear", 32'(done[0]), 0);
    check("ack_idle_busy", 32'(busy[0]), 0);

    // Overflow then a clean measurement
    do_arm(0);
    measure(0, 300, 255, 1);
    wait_done(0);
    read(0, 0);
    do_arm(0);
    measure(0, 20, 20, 0);
    wait_done(0);
    read(0, 0);

    // Continuous mode re-arms on acknowledge
    mode = 1'b1;
    do_arm(0);
    measure(0, 5, 5, 0);
    wait_done(0);
    read(0, 1);
    check("cont_rearm_busy", 32'(busy[0]), 1);
    measure(0, 7, 7, 0);
    wait_done(0);
    read(0, 0);
    check("cont_exit_busy", 32'(busy[0]), 0);

    // Simultaneous start and stop while ARMED: stop ignored
    do_arm(0);
    start_in[0] = 1'b1; stop_in[0] = 1'b1;
    tick();
    start_in[0] = 1'b0; stop_in[0] = 1'b0;
    tick(2);
    stop_in[0] = 1'b1;
    sb_q.push_back(exp_t'{0, 3, 1'b0});
    tick();
    stop_in[0] = 1'b0;
    wait_done(0);
    read(0, 0);

    // Stop while IDLE
    stop_in[1] = 1'b1;
    tick();
    stop_in[1] = 1'b0;
    tick(5);
    check("idle_stop_done", 32'(done[1]), 0);
    check("idle_stop_busy", 32'(busy[1]), 0);

    // Second start during RUN does not restart the count
    do_arm(0);
    start_in[0] = 1'b1;
    tick();
    start_in[0] = 1'b0;
    tick(2);
    start_in[0] = 1'b1;
    tick();
    start_in[0] = 1'b0;
    tick(2);
    stop_in[0] = 1'b1;
    sb_q.push_back(exp_t'{0, 6, 1'b0});
    tick();
    stop_in[0] = 1'b0;
    wait_done(0);
    read(0, 0);

    // Four concurrent channels measuring 4, 8, 12, 16
    arm = 6'b001111;
    tick();
    arm = '0;
    start_in = 6'b001111;
    for (int c = 1; c <= 16; c++) begin
      tick();
      start_in = '0;
      stop_in  = '0;
      for (int k = 0; k < 4; k++) if (c == 4 * (k + 1)) stop_in[k] = 1'b1;
    end
    tick();
    stop_in = '0;
    wait_done(3);
    check("multi_done", 32'(done), 32'h0F);
    for (int k = 0; k < 4; k++) begin
      sel = SW'(k);
      #1;
      check("sweep_count", 32'(count_out), 4 * (k + 1));
      check("sweep_ovf", 32'(ovf_out), 0);
    end
    sel = 3'd5; #1;
    check("sel5_count", 32'(count_out), 0);
    sel = 3'd6; #1;
    check("sel6_count", 32'(count_out), 0);
    sel = 3'd7; #1;
    check("sel7_ovf", 32'(ovf_out), 0);
    rd_ack = 1'b1;
    tick();
    rd_ack = 1'b0;
    check("oob_ack_done", 32'(done), 32'h0F);
    sb_q.push_back(exp_t'{2, 12, 1'b0});
    read(2, 0);
    check("ack2_done", 32'(done), 32'h0B);
    sb_q.push_back(exp_t'{0, 4, 1'b0});
    sb_q.push_back(exp_t'{1, 8, 1'b0});
    sb_q.push_back(exp_t'{3, 16, 1'b0});
    read(0, 0);
    read(1, 0);
    read(3, 0);
    check("multi_all_clear", 32'(done), 0);

    // Reset during channel 1 RUN
    do_arm(1);
    start_in[1] = 1'b1;
    tick();
    start_in[1] = 1'b0;
    tick(4);
    check("pre_rst_busy", 32'(busy[1]), 1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    sel = 3'd1; #1;
    check("rst_busy", 32'(busy), 0);
    check("rst_done", 32'(done), 0);
    check("rst_count", 32'(count_out), 0);
    check("rst_ovf", 32'(ovf_out), 0);
    stop_in[1] = 1'b1;
    tick();
    stop_in[1] = 1'b0;
    tick(6);
    check("post_rst_stop_done", 32'(done), 0);

    check("scoreboard_empty", 32'(sb_q.size()), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
